fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_buffer.sv | 133 +++++++++++++
 tb/tb_fetch_buffer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues in-order word fetches, queues returned instructions
// and feeds the decode register, squashing stale traffic on a decode-stage redirect.
module fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic [31:0] InstrD,
    output logic [31:0] PCPD,
    output logic        ValidD
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    logic [31:0]   pc;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pcp   [DEPTH];
    logic [PW-1:0] q_rd;
    logic [PW-1:0] q_wr;
    logic [CW-1:0] q_cnt;
    logic [31:0]   iss_pcp [DEPTH];
    logic [PW-1:0] iss_rd;
    logic [PW-1:0] iss_wr;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW:0]   in_use;
    logic          req_fire;
    logic          rsp_keep;
    logic          q_pop;

    // Queue slots are reserved at issue time, so a response always finds room.
    assign in_use         = {1'b0, q_cnt} + {1'b0, outstanding};
    assign imem_req_valid = !rst && !PCSrcD && (in_use < (CW+1)'(DEPTH));
    assign imem_req_addr  = {pc[31:2], 2'b00};
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && !PCSrcD && (discard == '0);
    assign q_pop          = !PCSrcD && !StallD && (q_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            q_rd        <= '0;
            q_wr        <= '0;
            q_cnt       <= '0;
            iss_rd      <= '0;
            iss_wr      <= '0;
            outstanding <= '0;
            discard     <= '0;
            InstrD      <= '0;
            PCPD        <= '0;
            ValidD      <= 1'b0;
        end else begin
            if (PCSrcD) begin
                pc <= PCBranchD;
            end else if (req_fire) begin
                pc <= pc + 32'd4;
            end

            // Issue-address FIFO tracks every in-flight request, stale or not.
            if (req_fire) begin
                iss_pcp[iss_wr] <= imem_req_addr + 32'd4;
                iss_wr          <= ptr_inc(iss_wr);
            end
            if (imem_rsp_valid) begin
                iss_rd <= ptr_inc(iss_rd);
            end

            case ({req_fire, imem_rsp_valid})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: ;
            endcase

            if (PCSrcD) begin
                discard <= imem_rsp_valid ? outstanding - CW'(1) : outstanding;
            end else if (imem_rsp_valid && (discard != '0)) begin
                discard <= discard - CW'(1);
            end

            if (PCSrcD) begin
                q_rd  <= '0;
                q_wr  <= '0;
                q_cnt <= '0;
            end else begin
                if (rsp_keep) begin
                    q_instr[q_wr] <= imem_rsp_data;
                    q_pcp[q_wr]   <= iss_pcp[iss_rd];
                    q_wr          <= ptr_inc(q_wr);
                end
                if (q_pop) begin
                    q_rd <= ptr_inc(q_rd);
                end
                case ({rsp_keep, q_pop})
                    2'b10:   q_cnt <= q_cnt + CW'(1);
                    2'b01:   q_cnt <= q_cnt - CW'(1);
                    default: ;
                endcase
            end

            if (PCSrcD) begin
                InstrD <= '0;
                PCPD   <= '0;
                ValidD <= 1'b0;
            end else if (!StallD) begin
                if (q_cnt != '0) begin
                    InstrD <= q_instr[q_rd];
                    PCPD   <= q_pcp[q_rd];
                    ValidD <= 1'b1;
                end else begin
                    InstrD <= '0;
                    PCPD   <= '0;
                    ValidD <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: transaction-level reference model (instruction queue plus
// in-flight list with stale flags) against a randomized in-order memory.
module tb_fetch_buffer;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b1;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        StallD = 1'b0;
    logic        PCSrcD = 1'b0;
    logic [31:0] PCBranchD = '0;
    logic [31:0] InstrD;
    logic [31:0] PCPD;
    logic        ValidD;

    fetch_buffer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .StallD(StallD), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
        .InstrD(InstrD), .PCPD(PCPD), .ValidD(ValidD)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } mem_t;
    typedef struct { logic [31:0] pcp; bit stale; } fly_t;
    typedef struct { logic [31:0] instr; logic [31:0] pcp; } ent_t;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 0;

    logic        t_rst = 1'b1, t_stall = 1'b0, t_redir = 1'b0, t_ready = 1'b1;
    logic [31:0] t_target = '0;
    int          lat_min = 1, lat_max = 1;

    mem_t mem[$];
    fly_t m_fly[$];
    ent_t m_q[$];
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_instr = '0, m_pcp = '0;
    logic        m_valid = 1'b0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs after the edge, compare at the falling edge, then advance
    // the memory and the reference model across the coming rising edge.
    task automatic cycle();
        logic exp_rv;
        logic fire;
        bit   got;
        ent_t e;
        fly_t f;
        mem_t m;
        @(posedge clk);
        #1;
        rst            = t_rst;
        StallD         = t_stall;
        PCSrcD         = t_redir;
        PCBranchD      = t_target;
        imem_req_ready = t_ready;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (!t_rst && mem.size() > 0 && mem[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data(mem[0].addr);
            void'(mem.pop_front());
        end
        @(negedge clk);
        exp_rv = !rst && !PCSrcD && ((m_q.size() + m_fly.size()) < DEPTH);
        if (chk_en) begin
            check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
            if (exp_rv) check("req_addr", imem_req_addr, {m_pc[31:2], 2'b00});
            check("InstrD", InstrD, m_instr);
            check("PCPD", PCPD, m_pcp);
            check("ValidD", 32'(ValidD), 32'(m_valid));
        end
        if (rst) begin
            mem.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            m.addr = imem_req_addr;
            m.due  = cyc + $urandom_range(lat_max, lat_min);
            mem.push_back(m);
        end
        if (rst) begin
            m_pc = RESET_PC;
            m_q.delete();
            m_fly.delete();
            m_instr = '0; m_pcp = '0; m_valid = 1'b0;
            chk_en = 1;
        end else begin
            fire = exp_rv && imem_req_ready;
            got  = 0;
            if (imem_rsp_valid && m_fly.size() > 0) begin
                f = m_fly.pop_front();
                if (!f.stale && !PCSrcD) begin
                    got     = 1;
                    e.instr = imem_rsp_data;
                    e.pcp   = f.pcp;
                end
            end
            if (PCSrcD) begin
                m_pc = PCBranchD;
                m_q.delete();
                foreach (m_fly[i]) m_fly[i].stale = 1;
                m_instr = '0; m_pcp = '0; m_valid = 1'b0;
            end else begin
                if (!StallD) begin
                    if (m_q.size() > 0) begin
                        ent_t h;
                        h = m_q.pop_front();
                        m_instr = h.instr; m_pcp = h.pcp; m_valid = 1'b1;
                    end else begin
                        m_instr = '0; m_pcp = '0; m_valid = 1'b0;
                    end
                end
                if (got) m_q.push_back(e);
                if (fire) begin
                    f.pcp   = {m_pc[31:2], 2'b00} + 32'd4;
                    f.stale = 0;
                    m_fly.push_back(f);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int  accepts;
        bit  found;

        // Reset state
        t_rst = 1'b1;
        cycle();
        cycle();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_ValidD", 32'(ValidD), 32'd0);
        check("rst_PCPD", PCPD, 32'd0);

        // Back-to-back stream with 1-cycle memory
        t_rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (k < 3) begin
                check("s034_addr", imem_req_addr, 32'(k * 4));
                check("s034_valid", 32'(imem_req_valid), 32'd1);
            end
            if (k == 2) check("s034_bubble", 32'(ValidD), 32'd0);
            if (k >= 3) begin
                check("s034_ValidD", 32'(ValidD), 32'd1);
                check("s034_PCPD", PCPD, 32'((k - 2) * 4));
            end
        end

        // Decode stall fills the queue, then the stream resumes
        t_stall = 1'b1;
        accepts = 0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (imem_req_valid && imem_req_ready) accepts++;
        end
        check("s035_accepts_le_depth", 32'(accepts <= DEPTH), 32'd1);
        t_stall = 1'b0;
        for (int k = 0; k < 8; k++) cycle();

        // Redirect with requests in flight
        lat_min = 2; lat_max = 2;
        for (int k = 0; k < 4; k++) cycle();
        t_redir = 1'b1; t_target = 32'h0000_0100;
        cycle();
        t_redir = 1'b0;
        cycle();
        check("s036_addr", imem_req_addr, 32'h0000_0100);
        check("s036_bubble", 32'(ValidD), 32'd0);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle();
            if (ValidD) found = 1;
        end
        check("s036_first_valid", 32'(found), 32'd1);
        check("s036_first_pcp", PCPD, 32'h0000_0104);

        // Redirect coinciding with a response while stalled
        found = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            if (mem.size() > 0 && mem[0].due <= cyc) found = 1;
            else cycle();
        end
        check("s037_setup", 32'(found), 32'd1);
        t_redir = 1'b1; t_stall = 1'b1; t_target = 32'h0000_0040;
        cycle();
        t_redir = 1'b0;
        cycle();
        check("s037_cleared", 32'(ValidD), 32'd0);
        t_stall = 1'b0;
        lat_min = 1; lat_max = 1;
        for (int k = 0; k < 4; k++) cycle();

        // Backpressure holds the request; PC wraps past the top of memory
        t_redir = 1'b1; t_target = 32'h0000_0200; t_ready = 1'b0;
        cycle();
        t_redir = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("s038_hold_addr", imem_req_addr, 32'h0000_0200);
            check("s038_hold_valid", 32'(imem_req_valid), 32'd1);
        end
        t_ready = 1'b1;
        cycle();
        t_redir = 1'b1; t_target = 32'hFFFF_FFFC;
        cycle();
        t_redir = 1'b0;
        cycle();
        check("s038_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        cycle();
        check("s038_wrap_addr", imem_req_addr, 32'h0000_0000);

        // Reset with the queue full and requests in flight
        lat_min = 2; lat_max = 2;
        t_stall = 1'b1;
        for (int k = 0; k < 6; k++) cycle();
        t_rst = 1'b1;
        cycle();
        check("s039_rst_req_valid", 32'(imem_req_valid), 32'd0);
        t_rst = 1'b0; t_stall = 1'b0;
        cycle();
        check("s039_ValidD", 32'(ValidD), 32'd0);
        check("s039_InstrD", InstrD, 32'd0);
        check("s039_PCPD", PCPD, 32'd0);
        check("s039_addr", imem_req_addr, RESET_PC);
        check("s039_req_valid", 32'(imem_req_valid), 32'd1);

        // Randomized traffic
        lat_min = 1; lat_max = 3;
        for (int k = 0; k < 3000; k++) begin
            t_rst   = ($urandom_range(199, 0) == 0);
            t_stall = ($urandom_range(9, 0) < 3);
            t_redir = ($urandom_range(19, 0) == 0);
            t_ready = ($urandom_range(3, 0) != 0);
            case ($urandom_range(3, 0))
                0:       t_target = 32'hFFFF_FFF8;
                1:       t_target = $urandom;
                default: t_target = {20'h0, $urandom_range(4095, 0)};
            endcase
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
